conv_job_scheduler: RTL
=======================

// Module: conv_job_scheduler
// PURPOSE
//  Shares one convolution engine (start/done handshake, filter-count input) among NUM_REQ requesters.
//  Each requester raises a job; a round-robin arbiter grants one.
//  The scheduler launches the engine, waits for done under a watchdog, then returns ack or err.
//  Sits between requester front-ends and the convolution top-level.
// PARAMETERS
//  NUM_REQ   4     number of requesters (>=2)
//  FILTER_W  3     width of per-job filter count
//  TIMEOUT   1023  max RUN cycles before the job is aborted
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst_n      in   1                  asynchronous active-low reset
//  req        in   NUM_REQ            per-requester job request, level, held until ack/err
//  req_nfilt  in   NUM_REQ*FILTER_W   packed filter counts, slice i = [i*FILTER_W +: FILTER_W]
//  grant      out  NUM_REQ            one-hot owner of the engine, 0 when idle
//  ack        out  NUM_REQ            1-cycle pulse: job finished OK
//  err        out  NUM_REQ            1-cycle pulse: job rejected or timed out
//  eng_start  out  1                  1-cycle start pulse to the engine
//  eng_nfilt  out  FILTER_W           filter count presented to the engine, held during job
//  eng_abort  out  1                  1-cycle pulse on watchdog expiry
//  eng_done   in   1                  engine completion pulse
//  busy       out  1                  high in every state except IDLE
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous, active-low (rst_n).
//  - Reset state:
//    - all outputs 0; state=IDLE; rr_ptr=0; wdog=0.
//    - rst_n low mid-job drops grant/eng_start at once; no ack/err is issued for that job.
//  - FSM IDLE -> LAUNCH -> RUN -> RESP -> IDLE. All outputs registered.
//  - IDLE, when any req is high:
//    - Pick the winner w: first set bit scanning up from rr_ptr, wrapping modulo NUM_REQ.
//    - Latch nfilt_w into eng_nfilt; set grant[w].
//    - If nfilt_w==0, go to RESP with reject flag set. The engine is never started.
//    - Otherwise go to LAUNCH.
//  - LAUNCH (1 cycle): eng_start=1; wdog cleared; go to RUN.
//  - RUN: wdog increments each cycle.
//    - eng_done=1: go to RESP, ok.
//    - wdog==TIMEOUT-1 without done: eng_abort=1 that cycle; go to RESP, timeout.
//    - eng_done coincident with the timeout cycle counts as done (ok, no abort).
//  - RESP (1 cycle):
//    - ack[w]=1 if ok, else err[w]=1.
//    - rr_ptr <= (w+1) mod NUM_REQ.
//    - grant clears on exit; go to IDLE.
//  - Latency:
//    - req rising in IDLE at edge t -> grant and eng_start high after edge t+1.
//    - eng_done sampled at edge d -> ack high after edge d+1.
//    - Zero-filter reject: err 2 cycles after req.
//  - eng_done outside RUN is ignored.
//  - req and req_nfilt changes after grant are ignored; the job runs with latched values.
//  - req dropped mid-job: the job still completes and ack/err is still pulsed.
//  - Requester still holding req after ack can win again, but only after others per rr_ptr.
//  - Min gap between jobs: 1 IDLE cycle.
//  - eng_nfilt holds its value after the job until the next grant.
//  - grant stays one-hot or zero; ack/err never both set; at most one bit of each set.
// STRUCTURE
//  - Package conv_sched_pkg:
//    - state enum typedef {IDLE, LAUNCH, RUN, RESP};
//    - localparam PTR_W = $clog2(NUM_REQ);
//    - localparam WDOG_W = $clog2(TIMEOUT+1).
//  - Sub-module conv_rr_arbiter: combinational.
//    - Inputs: req, rr_ptr.
//    - Outputs: one-hot win, win_idx, any.
//  - Top holds the FSM, latches, watchdog and output registers.
// TESTING
//  1. Single job: req=0001, nfilt0=3, eng_done 20 cycles after start.
//     -> eng_start 1 cycle, eng_nfilt=3, grant=0001; ack=0001 1 cycle after done; busy low next cycle.
//  2. Fairness: req=1111 held, done 5 cycles after each start.
//     -> grant order 0001,0010,0100,1000,0001; ack on each.
//  3. Zero filters: req=0100, nfilt2=0.
//     -> err=0100 two cycles later; eng_start never asserted; rr_ptr=3.
//  4. Timeout: TIMEOUT=8, req=0010, no done.
//     -> eng_abort after 8 RUN cycles, err=0010 next cycle.
//     -> done exactly on the 8th RUN cycle gives ack, no abort.
//  5. Stray/robust: eng_done pulsed in IDLE -> no response.
//     -> req dropped mid-RUN still gives ack; nfilt changed mid-job leaves eng_nfilt unchanged.
//  6. Reset mid-RUN: rst_n low.
//     -> all outputs 0 asynchronously; after release, req=1000 wins first (rr_ptr=0 scan).

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the convolution job scheduler.
// The state encoding is exported so debug monitors can decode dbg_state_o.
package conv_sched_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int FILTER_W_DEF = 3;
    localparam int TIMEOUT_DEF  = 1023;

    localparam int PTR_W  = $clog2(NUM_REQ_DEF);
    localparam int WDOG_W = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Round-robin successor of idx in a ring of n slots.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/conv_job_scheduler_if.sv
// Requester and engine signals of the job scheduler, bundled with modports.
// Protocol: req is a level held until ack/err; ack, err, eng_start, eng_abort and eng_done are 1-cycle pulses.
interface conv_job_scheduler_if #(
    parameter int NUM_REQ  = 4,
    parameter int FILTER_W = 3
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*FILTER_W-1:0] req_nfilt;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          ack;
    logic [NUM_REQ-1:0]          err;
    logic                        eng_start;
    logic [FILTER_W-1:0]         eng_nfilt;
    logic                        eng_abort;
    logic                        eng_done;
    logic                        busy;

    // Scheduler side.
    modport slave (
        input  req, req_nfilt, eng_done,
        output grant, ack, err, eng_start, eng_nfilt, eng_abort, busy
    );

    // Requester front-ends and engine side.
    modport master (
        output req, req_nfilt, eng_done,
        input  grant, ack, err, eng_start, eng_nfilt, eng_abort, busy
    );
endinterface

// File: rtl/conv_rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning up from rr_ptr, wrapping.
// No state here; the caller owns and advances the pointer.
module conv_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    int idx;

    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                win_o[idx] = 1'b1;
                win_idx_o  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/conv_job_scheduler.sv
// Shares one convolution engine among NUM_REQ requesters: round-robin grant,
// launch, watchdog-guarded run, then a single ack or err pulse to the owner.
module conv_job_scheduler
    import conv_sched_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int FILTER_W = FILTER_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_job_scheduler_if.slave  bus,
    output logic [1:0]           dbg_state_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;
    logic                ok_q, ok_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                start_q, start_d;
    logic                abort_q, abort_d;
    logic                busy_q, busy_d;
    logic [FILTER_W-1:0] nfilt_q, nfilt_d;

    logic [NUM_REQ-1:0]  win;
    logic [IDX_W-1:0]    win_idx;
    logic                any;
    logic [FILTER_W-1:0] win_nfilt;

    conv_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i     (bus.req),
        .rr_ptr_i  (rr_ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (any)
    );

    assign win_nfilt = bus.req_nfilt[int'(win_idx)*FILTER_W +: FILTER_W];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        wdog_d   = wdog_q;
        ok_d     = ok_q;
        grant_d  = grant_q;
        ack_d    = '0;
        err_d    = '0;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        nfilt_d  = nfilt_q;

        case (state_q)
            IDLE: begin
                if (any) begin
                    owner_d = win_idx;
                    grant_d = win;
                    nfilt_d = win_nfilt;
                    // A zero-filter job is rejected without touching the engine.
                    if (win_nfilt == '0) begin
                        ok_d    = 1'b0;
                        state_d = RESP;
                    end else begin
                        start_d = 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wdog_d = wdog_q + CNT_W'(1);
                // Done wins over a coincident watchdog expiry.
                if (bus.eng_done) begin
                    ok_d    = 1'b1;
                    state_d = RESP;
                end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
                    ok_d    = 1'b0;
                    abort_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (ok_q) ack_d[owner_q] = 1'b1;
                else      err_d[owner_q] = 1'b1;
                rr_ptr_d = IDX_W'(next_idx(int'(owner_q), NUM_REQ));
                grant_d  = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wdog_q   <= '0;
            ok_q     <= 1'b0;
            grant_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            nfilt_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wdog_q   <= wdog_d;
            ok_q     <= ok_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
            nfilt_q  <= nfilt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.eng_start = start_q;
    assign bus.eng_abort = abort_q;
    assign bus.eng_nfilt = nfilt_q;
    assign bus.busy      = busy_q;
    assign dbg_state_o   = state_q;

endmodule
